// File: rtl/pending_event_dispatcher_pkg.sv
// Shared helpers for the pending event dispatcher and its selector.
// Latency: none (compile-time helpers only).
// Backpressure: not applicable.
//
// Contents: clog2() used to derive index widths from source counts.
package pending_event_dispatcher_pkg;

  // Number of bits needed to encode values 0..value-1 (minimum 1 for value >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pending_event_dispatcher_round_robin_selector.sv
// Round-robin selector: first set request bit at or above pointer, with wrap-around.
// Latency: purely combinational.
// Backpressure: none; caller decides when to act on the grant.
//
// Ports:
//   request      in   WIDTH        request vector
//   pointer      in   INDEX_WIDTH  lowest index with priority this cycle (< WIDTH)
//   grant_valid  out  1            any request bit set
//   grant_index  out  INDEX_WIDTH  selected request index
module round_robin_selector
  import pending_event_dispatcher_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INDEX_WIDTH = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       request,
  input  logic [INDEX_WIDTH-1:0] pointer,
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index
);

  logic [2*WIDTH-1:0] doubled;
  logic [2*WIDTH-1:0] mask;
  logic [2*WIDTH-1:0] masked;

  // The request vector is laid out twice; bits below the pointer in the lower
  // copy are masked off, so the lowest surviving bit is the first request at or
  // above the pointer, and the upper copy supplies the wrap-around candidates.
  always_comb begin
    doubled     = {request, request};
    mask        = '0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      mask[i] = (i >= int'(pointer));
    end
    masked      = doubled & mask;
    grant_valid = |request;
    grant_index = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 2 * WIDTH - 1; i >= 0; i--) begin
      if (masked[i]) begin
        if (i >= WIDTH) begin
          grant_index = INDEX_WIDTH'(i - WIDTH);
        end else begin
          grant_index = INDEX_WIDTH'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pending_event_dispatcher.sv
// Sticky pending flags for event pulses, drained one index at a time round-robin.
// Latency: pulse at edge t -> pending after t, out_valid/out_index after t+1 if slot free.
// Backpressure: out_ready low freezes the slot; new events accumulate in pending/overflow.
//
// Ports:
//   clock, resetn     clock and asynchronous active-low reset
//   event_set         one pulse per event occurrence per source
//   overflow_clear    write-1-to-clear for overflow bits (set wins over clear)
//   out_valid/ready   valid/ready handshake for the presented index
//   out_index         index of the presented event
//   pending           pending flags, excluding the index held in the slot
//   overflow          sticky: event arrived while its flag was already pending
module pending_event_dispatcher
  import pending_event_dispatcher_pkg::*;
#(
  parameter  int EVENT_COUNT = 8,
  localparam int INDEX_WIDTH = clog2(EVENT_COUNT)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [EVENT_COUNT-1:0] event_set,
  input  logic [EVENT_COUNT-1:0] overflow_clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [EVENT_COUNT-1:0] pending,
  output logic [EVENT_COUNT-1:0] overflow
);

  logic [INDEX_WIDTH-1:0] pointer;
  logic                   grant_valid;
  logic [INDEX_WIDTH-1:0] grant_index;
  logic                   slot_load;
  logic [EVENT_COUNT-1:0] load_vec;
  logic [EVENT_COUNT-1:0] pending_next;
  logic [EVENT_COUNT-1:0] overflow_set;
  logic [EVENT_COUNT-1:0] overflow_next;
  logic [INDEX_WIDTH-1:0] pointer_next;

  // Selection looks only at the registered flags, so events arriving this
  // cycle are not eligible until the next one.
  round_robin_selector #(
    .WIDTH       (EVENT_COUNT),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_selector (
    .request     (pending),
    .pointer     (pointer),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  always_comb begin
    slot_load = ~out_valid | out_ready;
    load_vec  = '0;
    if (slot_load && grant_valid) begin
      load_vec = {{(EVENT_COUNT-1){1'b0}}, 1'b1} << grant_index;
    end
    // A new event on the index being loaded keeps the flag set: it is a fresh
    // occurrence, not a duplicate, so it also does not count as overflow.
    pending_next  = event_set | (pending & ~load_vec);
    overflow_set  = event_set & pending & ~load_vec;
    overflow_next = overflow_set | (overflow & ~overflow_clear);
    if (grant_index == INDEX_WIDTH'(EVENT_COUNT - 1)) begin
      pointer_next = '0;
    end else begin
      pointer_next = grant_index + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending   <= '0;
      overflow  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      pointer   <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
      if (slot_load) begin
        if (grant_valid) begin
          out_valid <= 1'b1;
          out_index <= grant_index;
          pointer   <= pointer_next;
        end else begin
          // Nothing to present: slot empties, index and pointer keep their values.
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pending_event_dispatcher.sv
// Directed table-driven bench for pending_event_dispatcher (EVENT_COUNT = 8).
// Each record drives one cycle of inputs and lists the outputs expected after that edge.
module tb_pending_event_dispatcher;

  logic       clock;
  logic       resetn;
  logic [7:0] event_set;
  logic [7:0] overflow_clear;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic [7:0] pending;
  logic [7:0] overflow;

  int n_applied;
  int n_miscompares;

  typedef struct {
    logic [7:0] ev;
    logic [7:0] clr;
    logic       rdy;
    logic       exp_valid;
    logic [2:0] exp_index;
    logic [7:0] exp_pending;
    logic [7:0] exp_overflow;
  } vec_t;

  vec_t vecs[$];

  pending_event_dispatcher #(.EVENT_COUNT(8)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .event_set      (event_set),
    .overflow_clear (overflow_clear),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .pending        (pending),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic vld, input logic [2:0] idx,
                       input logic [7:0] pend, input logic [7:0] ovf);
    bit bad;
    bad = 1'b0;
    n_applied++;
    if (out_valid !== vld) begin
      $display("FAIL %s out_valid got %b want %b", name, out_valid, vld);
      bad = 1'b1;
    end
    if (out_index !== idx) begin
      $display("FAIL %s out_index got %0d want %0d", name, out_index, idx);
      bad = 1'b1;
    end
    if (pending !== pend) begin
      $display("FAIL %s pending got %h want %h", name, pending, pend);
      bad = 1'b1;
    end
    if (overflow !== ovf) begin
      $display("FAIL %s overflow got %h want %h", name, overflow, ovf);
      bad = 1'b1;
    end
    if (bad) n_miscompares++;
  endtask

  task automatic add(input logic [7:0] ev, input logic [7:0] clr, input logic rdy,
                     input logic vld, input logic [2:0] idx,
                     input logic [7:0] pend, input logic [7:0] ovf);
    vec_t v;
    v.ev = ev; v.clr = clr; v.rdy = rdy;
    v.exp_valid = vld; v.exp_index = idx; v.exp_pending = pend; v.exp_overflow = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    n_applied      = 0;
    n_miscompares  = 0;
    resetn         = 1'b0;
    event_set      = '0;
    overflow_clear = '0;
    out_ready      = 1'b0;

    //     ev     clr    rdy   vld idx pend   ovf
    // Round robin from pointer 0: 0x85 -> 0,2,7, then again after wrap.
    add(8'h85, 8'h00, 1'b1, 1'b0, 3'd0, 8'h85, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 8'h84, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h80, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 8'h00, 8'h00);
    add(8'h85, 8'h00, 1'b1, 1'b0, 3'd7, 8'h85, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 8'h84, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h80, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 8'h00, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 8'h00);
    // Single event on source 3: pending after t, slot after t+1, empty after handshake.
    add(8'h08, 8'h00, 1'b1, 1'b0, 3'd7, 8'h08, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd3, 8'h00, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00);
    // Backpressure: slot holds 5 while 1 and 6 arrive; release picks 6 then wraps to 1.
    add(8'h20, 8'h00, 1'b0, 1'b0, 3'd3, 8'h20, 8'h00);
    add(8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h00, 8'h00);
    add(8'h02, 8'h00, 1'b0, 1'b1, 3'd5, 8'h02, 8'h00);
    add(8'h40, 8'h00, 1'b0, 1'b1, 3'd5, 8'h42, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd6, 8'h02, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00);
    // Overflow: hold slot busy on 0, double event on 2, clear racing a set, then clear.
    add(8'h01, 8'h00, 1'b0, 1'b0, 3'd1, 8'h01, 8'h00);
    add(8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
    add(8'h04, 8'h00, 1'b0, 1'b1, 3'd0, 8'h04, 8'h00);
    add(8'h04, 8'h00, 1'b0, 1'b1, 3'd0, 8'h04, 8'h04);
    add(8'h04, 8'h04, 1'b0, 1'b1, 3'd0, 8'h04, 8'h04);
    add(8'h00, 8'h04, 1'b0, 1'b1, 3'd0, 8'h04, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h00, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 8'h00);
    // Same-cycle load and set on source 0: flag survives, no overflow, delivered twice.
    add(8'h01, 8'h00, 1'b1, 1'b0, 3'd2, 8'h01, 8'h00);
    add(8'h01, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    // Set up slot valid with pending 0xF0 ahead of the reset test.
    add(8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 8'h00);
    add(8'hF0, 8'h00, 1'b0, 1'b1, 3'd0, 8'hF0, 8'h00);

    // Reset state while held in reset across an edge.
    @(posedge clock);
    #1;
    check("reset_hold", 1'b0, 3'd0, 8'h00, 8'h00);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      event_set      = vecs[i].ev;
      overflow_clear = vecs[i].clr;
      out_ready      = vecs[i].rdy;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_index,
            vecs[i].exp_pending, vecs[i].exp_overflow);
    end

    // Asynchronous reset mid-cycle clears the held slot and flags without a clock edge.
    event_set      = '0;
    overflow_clear = '0;
    out_ready      = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", 1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_idle", 1'b0, 3'd0, 8'h00, 8'h00);
    event_set = 8'h10;
    @(posedge clock);
    #1;
    check("post_reset_event", 1'b0, 3'd0, 8'h10, 8'h00);
    event_set = 8'h00;
    @(posedge clock);
    #1;
    check("post_reset_slot", 1'b1, 3'd4, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/pending_event_dispatcher.md
# pending_event_dispatcher

Collects single-cycle event pulses from up to EVENT_COUNT hardware sources into sticky pending flags. It presents one pending event index at a time on a valid/ready output, chosen by round-robin arbitration. It sits on the consumer side of the set/reset flag scheme: producers set flags, and this block drains them in order and clears each one on acceptance. Typical consumers are an interrupt controller or a sequencer that services one event per handshake.

## Interface
- EVENT_COUNT, 8, number of event sources; legal range 2..64.
- INDEX_WIDTH, $clog2(EVENT_COUNT), width of out_index; derived localparam, not overridable.
- clock  input  1  clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- event_set  input  EVENT_COUNT  one pulse per event; bit i high in a cycle marks one occurrence on source i.
- overflow_clear  input  EVENT_COUNT  write-1-to-clear for overflow bits.
- out_valid  output  1  output slot holds an event index.
- out_ready  input  1  consumer accepts the slot when out_valid & out_ready at a rising edge.
- out_index  output  INDEX_WIDTH  index of the presented event.
- pending  output  EVENT_COUNT  current pending flags; excludes the index held in the slot.
- overflow  output  EVENT_COUNT  sticky; bit i set when an event on i arrives while pending[i] is already 1.

## Operation
- Reset values: pending = 0, overflow = 0, out_valid = 0, out_index = 0, round-robin pointer = 0.
- Pending flag i, next-state priority:
  - event_set[i] has highest priority and sets the flag.
  - Otherwise, loading i into the slot this cycle clears the flag.
  - Otherwise the flag holds.
- If event_set[i] and a load of i occur in the same cycle, pending[i] stays 1. This is a new occurrence and is neither lost nor an overflow.
- overflow[i] sets when event_set[i] is high, pending[i] is 1, and i is not being loaded this cycle.
- overflow_clear[i] clears overflow[i]. If set and clear happen in the same cycle, set wins.
- The slot can load in a cycle when out_valid is 0, or when a handshake occurs that cycle.
- On load:
  - If any pending bit is 1, select the first pending index at or above the pointer, searching upward with wrap-around.
  - Register it into out_index, set out_valid = 1, and set pointer = selected + 1 mod EVENT_COUNT.
  - If no bit is pending, out_valid becomes 0 and out_index and pointer hold.
- Selection uses the pending register value before the current cycle's event_set. Same-cycle events are not eligible until the next cycle.
- While out_valid = 1 and out_ready = 0, out_valid and out_index are stable regardless of new events.
- An event on the index currently held in the slot only re-sets pending for that index. It is not an overflow.

## Timing
- Latency: event_set pulse sampled at edge t gives pending set after edge t, and out_valid = 1 with out_index after edge t+1, provided the slot is free.
- Throughput: one event per cycle with out_ready held high. Back-to-back loads on consecutive handshakes have no bubble.
- All outputs are registered. out_ready reaches only slot/pending next-state logic, with no combinational path to any output.
- Reset asserted mid-operation immediately clears all state, including an unaccepted slot. Events in the reset-deassertion cycle are sampled normally.

## Structure
- No shared package needed. Only the INDEX_WIDTH derivation is used, as a localparam using the codebase's existing clog2 helper.
- One sub-module: round_robin_selector.
  - Combinational.
  - Inputs: request vector and pointer. Outputs: grant_valid and grant_index.
  - Implemented as a double-width masked priority encoder.
  - Reusable by other arbiters.
- The top level holds the pending, overflow, slot and pointer registers, about 150-250 lines total.

## Test plan
- Single event: EVENT_COUNT = 8, pulse event_set = 0x08 at edge t, out_ready = 1 → out_valid = 1 with out_index = 3 after edge t+1; pending = 0; out_valid = 0 one cycle after the handshake.
- Round-robin: pending 0x85, pointer 0, out_ready = 1 → indices 0, 2, 7 on consecutive cycles. Re-pulse 0x85 → order continues 0, 2, 7 because pointer wrapped to 0.
- Backpressure: out_ready = 0 with slot = 5 while pulses arrive on 1 and 6 → out_index stays 5 and pending = 0x42. Raise out_ready → next index is 6 (pointer = 6).
- Overflow: pulse event_set[2] twice while the slot is held busy → overflow = 0x04. Assert overflow_clear[2] with a third event_set[2] in the same cycle → overflow[2] stays 1. A clear on the next cycle → 0.
- Same-cycle load and set: pending = 0x01 with the slot free, and event_set[0] high in the load cycle → slot = 0 and pending[0] stays 1. A second handshake delivers index 0 again, with no overflow.
- Reset mid-operation: out_valid = 1 and pending = 0xF0, then drop resetn asynchronously → all outputs 0 immediately. After release, the first event on 4 presents index 4.
